imem_qspi_fetch: RTL and testbench

Instruction-fetch unit serving the IMR phase of the CPU sequencer. When the sequencer is in IMR, it reads one 32-bit instruction from external quad-SPI memory at the current PC using a quad I/O fast-read. It holds `imr_run` high until the word is captured, then presents it on `inst` to the ID/RFR stage.

---
 rtl/imem_qspi_fetch.sv | 186 ++++++++++++++++++
 tb/tb_imem_qspi_fetch.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_qspi_fetch.sv
// Instruction fetch over quad-SPI: one 0xEB quad I/O fast-read of a 32-bit word per IMR request.
// SCK runs at clk/2; inst updates atomically when the word is complete.
module imem_qspi_fetch #(
    parameter int unsigned DUMMY_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_stat_imr,
    input  logic [31:0] pc,
    output logic        imr_run,
    output logic [31:0] inst,
    output logic        qspi_cs_n,
    output logic        qspi_sck,
    output logic [3:0]  qspi_dout,
    output logic        qspi_oe,
    input  logic [3:0]  qspi_din
);

    if (DUMMY_CYC < 1 || DUMMY_CYC > 15) begin : g_bad_dummy
        $error("DUMMY_CYC must be in 1..15");
    end

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StDummy,
        StData,
        StDone
    } state_e;

    localparam logic [31:0] InstReset = 32'h0000_0013;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        sck_q, sck_d;
    logic [23:0] addr_q, addr_d;
    logic [31:0] shift_q, shift_d;
    logic [31:0] inst_q, inst_d;

    logic [4:0]  last_cnt;
    state_e      next_phase;
    logic [3:0]  addr_nib;

    logic unused_pc;
    assign unused_pc = ^{pc[31:24], pc[1:0]};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 5'd0;
            sck_q   <= 1'b0;
            addr_q  <= 24'd0;
            shift_q <= 32'd0;
            inst_q  <= InstReset;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sck_q   <= sck_d;
            addr_q  <= addr_d;
            shift_q <= shift_d;
            inst_q  <= inst_d;
        end
    end

    // Per-phase SCK cycle count and successor
    always_comb begin
        last_cnt   = 5'd0;
        next_phase = StIdle;
        unique case (state_q)
            StCmd: begin
                last_cnt   = 5'd1;
                next_phase = StAddr;
            end
            StAddr: begin
                last_cnt   = 5'd5;
                next_phase = StDummy;
            end
            StDummy: begin
                last_cnt   = 5'(DUMMY_CYC - 1);
                next_phase = StData;
            end
            StData: begin
                last_cnt   = 5'd7;
                next_phase = StDone;
            end
            default: begin
                last_cnt   = 5'd0;
                next_phase = StIdle;
            end
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sck_d   = 1'b0;
        addr_d  = addr_q;
        shift_d = shift_q;
        inst_d  = inst_q;

        unique case (state_q)
            StIdle: begin
                if (cpu_stat_imr) begin
                    state_d = StCmd;
                    addr_d  = {pc[23:2], 2'b00};
                end
            end
            StCmd, StAddr, StDummy, StData: begin
                if (!cpu_stat_imr) begin
                    state_d = StIdle;
                end else begin
                    sck_d = ~sck_q;
                    if (sck_q) begin
                        cnt_d = cnt_q + 5'd1;
                        if (state_q == StData) begin
                            shift_d = {shift_q[27:0], qspi_din};
                        end
                        if (cnt_q == last_cnt) begin
                            state_d = next_phase;
                        end
                    end
                end
            end
            StDone: begin
                if (!cpu_stat_imr) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) begin
            cnt_d = 5'd0;
        end

        // Nibbles arrive high-first per byte, byte 0 first; the last one lands on this same edge.
        if (state_q == StData && state_d == StDone) begin
            inst_d = {shift_d[7:0], shift_d[15:8], shift_d[23:16], shift_d[31:24]};
        end
    end

    always_comb begin
        unique case (cnt_q[2:0])
            3'd0:    addr_nib = addr_q[23:20];
            3'd1:    addr_nib = addr_q[19:16];
            3'd2:    addr_nib = addr_q[15:12];
            3'd3:    addr_nib = addr_q[11:8];
            3'd4:    addr_nib = addr_q[7:4];
            3'd5:    addr_nib = addr_q[3:0];
            default: addr_nib = 4'h0;
        endcase
    end

    // Output decode
    always_comb begin
        qspi_cs_n = 1'b1;
        qspi_oe   = 1'b0;
        qspi_dout = 4'h0;
        unique case (state_q)
            StCmd: begin
                qspi_cs_n = 1'b0;
                qspi_oe   = 1'b1;
                qspi_dout = cnt_q[0] ? 4'hB : 4'hE;
            end
            StAddr: begin
                qspi_cs_n = 1'b0;
                qspi_oe   = 1'b1;
                qspi_dout = addr_nib;
            end
            StDummy, StData: begin
                qspi_cs_n = 1'b0;
            end
            default: begin
                qspi_cs_n = 1'b1;
            end
        endcase
    end

    assign qspi_sck = sck_q;
    assign inst     = inst_q;
    assign imr_run  = cpu_stat_imr & (state_q != StDone) & ~rst;

endmodule

// File: tb/tb_imem_qspi_fetch.sv
// Bench for imem_qspi_fetch: three instances (DUMMY_CYC 4, 1, 8) share stimulus, each with a
// behavioural quad-SPI memory; table-driven fetches plus abort and reset sequences.
module tb_imem_qspi_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imr;
    logic [31:0] pc;

    logic        imr_run_w [3];
    logic [31:0] inst_w    [3];
    logic        cs_n_w    [3];
    logic        sck_w     [3];
    logic        oe_w      [3];
    logic [3:0]  dout_w    [3];
    logic [3:0]  din_w     [3];

    int          mk        [3];
    logic [7:0]  obs_cmd   [3];
    logic [23:0] obs_addr  [3];

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] last_inst;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [23:0] addr;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            imem_qspi_fetch #(
                .DUMMY_CYC((g == 0) ? 4 : ((g == 1) ? 1 : 8))
            ) u_dut (
                .clk         (clk),
                .rst         (rst),
                .cpu_stat_imr(imr),
                .pc          (pc),
                .imr_run     (imr_run_w[g]),
                .inst        (inst_w[g]),
                .qspi_cs_n   (cs_n_w[g]),
                .qspi_sck    (sck_w[g]),
                .qspi_dout   (dout_w[g]),
                .qspi_oe     (oe_w[g]),
                .qspi_din    (din_w[g])
            );
        end
    endgenerate

    function automatic int dcyc(input int i);
        return (i == 0) ? 4 : ((i == 1) ? 1 : 8);
    endfunction

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        case (a)
            24'h000100: return 8'h93;
            24'h000101: return 8'h00;
            24'h000102: return 8'h10;
            24'h000103: return 8'h00;
            24'h000204: return 8'h13;
            24'h000205: return 8'h05;
            24'h000206: return 8'hA0;
            24'h000207: return 8'h00;
            24'hABCDE8: return 8'h6F;
            24'hABCDE9: return 8'h00;
            24'hABCDEA: return 8'h00;
            24'hABCDEB: return 8'h00;
            24'h3FFFFC: return 8'h78;
            24'h3FFFFD: return 8'h56;
            24'h3FFFFE: return 8'h34;
            24'h3FFFFF: return 8'h12;
            default:    return 8'hEE;
        endcase
    endfunction

    function automatic logic [3:0] mem_nib(input logic [23:0] a, input int j);
        logic [7:0] b;
        b = mem_byte(a + 24'(j / 2));
        return (j % 2 == 0) ? b[7:4] : b[3:0];
    endfunction

    // Memory model: acts on the high phase of each SCK cycle, so din is stable before the DUT samples
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (cs_n_w[i]) begin
                mk[i]    <= 0;
                din_w[i] <= 4'hF;
            end else if (sck_w[i]) begin
                if (mk[i] < 2) begin
                    obs_cmd[i] <= {obs_cmd[i][3:0], dout_w[i]};
                end else if (mk[i] < 8) begin
                    obs_addr[i] <= {obs_addr[i][19:0], dout_w[i]};
                end else if (mk[i] >= 8 + dcyc(i) && mk[i] < 16 + dcyc(i)) begin
                    din_w[i] <= mem_nib(obs_addr[i], mk[i] - 8 - dcyc(i));
                end
                mk[i] <= mk[i] + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Starts at posedge+1 (cycle T0); returns at posedge+1 after a single idle-request cycle
    task automatic fetch(input logic [31:0] p, input logic [31:0] exp_inst,
                         input logic [23:0] exp_addr);
        int cnt [3];
        bit finished;
        cnt      = '{0, 0, 0};
        finished = 1'b0;
        pc       = p;
        imr      = 1'b1;
        for (int t = 0; t < 80; t++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (imr_run_w[i]) cnt[i]++;
            end
            if (t == 0) chk("cs_n high at T0", 32'(cs_n_w[0]), 32'd1);
            if (t == 0) chk("imr_run at T0", 32'(imr_run_w[0]), 32'd1);
            if (t == 1) chk("cs_n low at T1", 32'(cs_n_w[0]), 32'd0);
            if (t == 40) chk("cs_n low at T40", 32'(cs_n_w[0]), 32'd0);
            if (t == 40) chk("inst held at T40", inst_w[0], last_inst);
            if (t == 41) chk("imr_run low at T41", 32'(imr_run_w[0]), 32'd0);
            if (t == 41) chk("cs_n high at T41", 32'(cs_n_w[0]), 32'd1);
            if (t == 41) chk("inst at T41", inst_w[0], exp_inst);
            if (!imr_run_w[0] && !imr_run_w[1] && !imr_run_w[2]) begin
                finished = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("fetch completed within budget", 32'(finished), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("imr_run cycles d%0d", dcyc(i)), 32'(cnt[i]), 32'(33 + 2 * dcyc(i)));
            chk($sformatf("inst d%0d", dcyc(i)), inst_w[i], exp_inst);
            chk($sformatf("addr nibbles d%0d", dcyc(i)), 32'(obs_addr[i]), 32'(exp_addr));
            chk($sformatf("cmd nibbles d%0d", dcyc(i)), 32'(obs_cmd[i]), 32'h0000_00EB);
        end
        last_inst = exp_inst;
        @(posedge clk);
        #1;
        imr = 1'b0;
        @(negedge clk);
        chk("cs_n high in gap", 32'(cs_n_w[0]), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{pc: 32'h0000_0100, inst: 32'h0010_0093, addr: 24'h000100};
        vecs[1] = '{pc: 32'h0000_0102, inst: 32'h0010_0093, addr: 24'h000100};
        vecs[2] = '{pc: 32'h0000_0204, inst: 32'h00A0_0513, addr: 24'h000204};
        vecs[3] = '{pc: 32'hFFAB_CDEB, inst: 32'h0000_006F, addr: 24'hABCDE8};
        vecs[4] = '{pc: 32'h003F_FFFD, inst: 32'h1234_5678, addr: 24'h3FFFFC};

        rst = 1'b1;
        imr = 1'b0;
        pc  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset cs_n d%0d", dcyc(i)), 32'(cs_n_w[i]), 32'd1);
            chk($sformatf("reset sck d%0d", dcyc(i)), 32'(sck_w[i]), 32'd0);
            chk($sformatf("reset oe d%0d", dcyc(i)), 32'(oe_w[i]), 32'd0);
            chk($sformatf("reset dout d%0d", dcyc(i)), 32'(dout_w[i]), 32'd0);
            chk($sformatf("reset imr_run d%0d", dcyc(i)), 32'(imr_run_w[i]), 32'd0);
            chk($sformatf("reset inst d%0d", dcyc(i)), inst_w[i], 32'h0000_0013);
        end
        last_inst = 32'h0000_0013;
        @(posedge clk);
        #1;

        // Back-to-back fetches, one idle-request cycle between each
        for (int v = 0; v < 5; v++) begin
            fetch(vecs[v].pc, vecs[v].inst, vecs[v].addr);
        end

        // Abort in DUMMY at T20
        pc  = 32'h0000_0204;
        imr = 1'b1;
        repeat (19) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("cs_n low before abort", 32'(cs_n_w[0]), 32'd0);
        @(posedge clk);
        #1;
        imr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort cs_n", 32'(cs_n_w[0]), 32'd1);
        chk("abort oe", 32'(oe_w[0]), 32'd0);
        chk("abort sck", 32'(sck_w[0]), 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("abort inst kept d%0d", dcyc(i)), inst_w[i], last_inst);
        end
        @(posedge clk);
        #1;
        fetch(vecs[0].pc, vecs[0].inst, vecs[0].addr);

        // Reset asserted at T30, checked at T31
        pc  = 32'h0000_0204;
        imr = 1'b1;
        repeat (30) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("mid reset cs_n d%0d", dcyc(i)), 32'(cs_n_w[i]), 32'd1);
            chk($sformatf("mid reset oe d%0d", dcyc(i)), 32'(oe_w[i]), 32'd0);
            chk($sformatf("mid reset sck d%0d", dcyc(i)), 32'(sck_w[i]), 32'd0);
            chk($sformatf("mid reset imr_run d%0d", dcyc(i)), 32'(imr_run_w[i]), 32'd0);
            chk($sformatf("mid reset inst d%0d", dcyc(i)), inst_w[i], 32'h0000_0013);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        imr = 1'b0;
        last_inst = 32'h0000_0013;
        @(posedge clk);
        #1;
        fetch(vecs[2].pc, vecs[2].inst, vecs[2].addr);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
